// File: rtl/l2_ins_pkg.sv
// Shared types and widths for the instruction-side L2 responder.
// The optional request queue is enabled by defining L2_INS_ADDR_QUEUE_EN.
package l2_ins_pkg;

    localparam int WORD_OFFSET_BITS      = 4;
    localparam int DEFAULT_ADDRESS_WIDTH = 32;
    localparam int DEFAULT_BUS_WIDTH     = 512;
    localparam int DEFAULT_LINE_COUNT    = 256;
    localparam int L2_ADDR_WIDTH         = DEFAULT_ADDRESS_WIDTH - 2;
    localparam int INDEX_WIDTH           = $clog2(DEFAULT_LINE_COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        RESP = 2'd3
    } l2_ins_state_e;

endpackage

// File: rtl/l2_ins_line_memory.sv
// Line store: one preload write port and one registered, read-first read port.
// Contents are deliberately not reset.
module l2_ins_line_memory #(
    parameter int L2_BUS_WIDTH = 512,
    parameter int LINE_COUNT   = 256,
    parameter int IDX_W        = $clog2(LINE_COUNT)
) (
    input  logic                    clk_i,
    input  logic                    wr_en_i,
    input  logic [IDX_W-1:0]        wr_idx_i,
    input  logic [L2_BUS_WIDTH-1:0] wr_line_i,
    input  logic                    rd_en_i,
    input  logic [IDX_W-1:0]        rd_idx_i,
    output logic [L2_BUS_WIDTH-1:0] rd_line_o
);

    logic [L2_BUS_WIDTH-1:0] mem_q [LINE_COUNT];
    logic [L2_BUS_WIDTH-1:0] rd_line_q;

    // Same-edge write and read of one index returns the old line.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_line_i;
        end
        if (rd_en_i) begin
            rd_line_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_line_o = rd_line_q;

endmodule

// File: rtl/l2_instruction_responder.sv
// L2-side responder for instruction-cache line fills: accept, wait, read, return.
// Define L2_INS_ADDR_QUEUE_EN to add a one-entry request queue.
module l2_instruction_responder
    import l2_ins_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int L2_BUS_WIDTH  = DEFAULT_BUS_WIDTH,
    parameter int LINE_COUNT    = DEFAULT_LINE_COUNT,
    parameter int LATENCY       = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          ADDRESS_TO_L2_VALID_INS,
    input  logic [ADDRESS_WIDTH-3:0]      ADDRESS_TO_L2_INS,
    output logic                          ADDRESS_TO_L2_READY_INS,
    output logic                          DATA_FROM_L2_VALID_INS,
    output logic [L2_BUS_WIDTH-1:0]       DATA_FROM_L2_INS,
    input  logic                          DATA_FROM_L2_READY_INS,
    input  logic                          INIT_VALID,
    input  logic [$clog2(LINE_COUNT)-1:0] INIT_INDEX,
    input  logic [L2_BUS_WIDTH-1:0]       INIT_LINE
);

    localparam int IDX_W = $clog2(LINE_COUNT);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(LATENCY);

    l2_ins_state_e           state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    valid_q, valid_d;
    logic                    ready_q, ready_d;
    logic [L2_BUS_WIDTH-1:0] data_q, data_d;
    logic [L2_BUS_WIDTH-1:0] mem_rdata_s;
    logic [IDX_W-1:0]        req_idx_s;
    logic                    accept_s;
    logic                    rd_en_s;
    logic                    unused_addr_s;

`ifdef L2_INS_ADDR_QUEUE_EN
    logic             q_full_q, q_full_d;
    logic [IDX_W-1:0] q_idx_q, q_idx_d;
    logic             push_s;
`endif

    // Word-offset bits and upper bits beyond the index are ignored (aliasing).
    assign req_idx_s     = ADDRESS_TO_L2_INS[IDX_W+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];
    assign unused_addr_s = ^ADDRESS_TO_L2_INS;
    assign accept_s      = ADDRESS_TO_L2_VALID_INS & ready_q;
    assign rd_en_s       = (state_q == WAIT) && (cnt_q == CNT_ONE);
`ifdef L2_INS_ADDR_QUEUE_EN
    assign push_s        = accept_s && (state_q != IDLE);
`endif

    l2_ins_line_memory #(
        .L2_BUS_WIDTH (L2_BUS_WIDTH),
        .LINE_COUNT   (LINE_COUNT)
    ) u_mem (
        .clk_i     (CLK),
        .wr_en_i   (INIT_VALID),
        .wr_idx_i  (INIT_INDEX),
        .wr_line_i (INIT_LINE),
        .rd_en_i   (rd_en_s),
        .rd_idx_i  (idx_q),
        .rd_line_o (mem_rdata_s)
    );

    // Next-state, counter, queue and output-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
`ifdef L2_INS_ADDR_QUEUE_EN
        q_full_d = q_full_q;
        q_idx_d  = q_idx_q;
        if (push_s) begin
            q_full_d = 1'b1;
            q_idx_d  = req_idx_s;
        end else begin
            q_full_d = q_full_q;
        end
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = WAIT;
                    cnt_d   = LAT_C;
                    idx_d   = req_idx_s;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = READ;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            READ: begin
                data_d  = mem_rdata_s;
                valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (DATA_FROM_L2_READY_INS) begin
                    valid_d = 1'b0;
`ifdef L2_INS_ADDR_QUEUE_EN
                    // A pending or same-edge request goes straight back to WAIT.
                    if (q_full_q) begin
                        state_d  = WAIT;
                        cnt_d    = LAT_C;
                        idx_d    = q_idx_q;
                        q_full_d = 1'b0;
                    end else if (push_s) begin
                        state_d  = WAIT;
                        cnt_d    = LAT_C;
                        idx_d    = req_idx_s;
                        q_full_d = 1'b0;
                    end else begin
                        state_d  = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                valid_d = 1'b0;
            end
        endcase
`ifdef L2_INS_ADDR_QUEUE_EN
        ready_d = ~q_full_d;
`else
        ready_d = (state_d == IDLE);
`endif
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            idx_q    <= {IDX_W{1'b0}};
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
            data_q   <= {L2_BUS_WIDTH{1'b0}};
`ifdef L2_INS_ADDR_QUEUE_EN
            q_full_q <= 1'b0;
            q_idx_q  <= {IDX_W{1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            data_q   <= data_d;
`ifdef L2_INS_ADDR_QUEUE_EN
            q_full_q <= q_full_d;
            q_idx_q  <= q_idx_d;
`endif
        end
    end

    assign ADDRESS_TO_L2_READY_INS = ready_q;
    assign DATA_FROM_L2_VALID_INS  = valid_q;
    assign DATA_FROM_L2_INS        = data_q;

endmodule

// File: tb/tb_l2_instruction_responder.sv
// Self-checking bench for l2_instruction_responder against a line-array reference model.
// Queue scenario is compiled only when L2_INS_ADDR_QUEUE_EN is defined.
module tb_l2_instruction_responder;

    localparam int AW    = 32;
    localparam int BW    = 512;
    localparam int LINES = 256;
    localparam int LAT   = 4;
    localparam int IW    = $clog2(LINES);

    logic          clk;
    logic          rst;
    logic          a_valid;
    logic [AW-3:0] a_addr;
    logic          a_ready;
    logic          d_valid;
    logic [BW-1:0] d_data;
    logic          d_ready;
    logic          init_valid;
    logic [IW-1:0] init_index;
    logic [BW-1:0] init_line;

    logic [BW-1:0] mem_model [LINES];
    int checks = 0;
    int errors = 0;

`ifdef L2_INS_ADDR_QUEUE_EN
    localparam logic BUSY_READY = 1'b1;
`else
    localparam logic BUSY_READY = 1'b0;
`endif

    l2_instruction_responder #(
        .ADDRESS_WIDTH (AW),
        .L2_BUS_WIDTH  (BW),
        .LINE_COUNT    (LINES),
        .LATENCY       (LAT)
    ) dut (
        .CLK                     (clk),
        .RST                     (rst),
        .ADDRESS_TO_L2_VALID_INS (a_valid),
        .ADDRESS_TO_L2_INS       (a_addr),
        .ADDRESS_TO_L2_READY_INS (a_ready),
        .DATA_FROM_L2_VALID_INS  (d_valid),
        .DATA_FROM_L2_INS        (d_data),
        .DATA_FROM_L2_READY_INS  (d_ready),
        .INIT_VALID              (init_valid),
        .INIT_INDEX              (init_index),
        .INIT_LINE               (init_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_line();
        logic [BW-1:0] l;
        for (int w = 0; w < BW / 32; w++) begin
            l[w*32 +: 32] = $urandom;
        end
        return l;
    endfunction

    function automatic int line_of(input logic [AW-3:0] addr);
        return int'((addr / 30'd16) % 30'(LINES));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for VALID; returns the number of edges waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (d_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    // One full transaction: request, latency, optional backpressure, handshake.
    task automatic do_fill(input logic [AW-3:0] addr, input int bp, input bit inject);
        logic [BW-1:0] exp_line;
        logic [BW-1:0] new_line;
        int idx;
        int n;
        idx      = line_of(addr);
        exp_line = mem_model[idx];
        new_line = rand_line();
        a_addr   = addr;
        a_valid  = 1'b1;
        check("req_ready", {511'd0, a_ready}, {511'd0, 1'b1});
        step();
        a_valid = 1'b0;
        check("ready_busy", {511'd0, a_ready}, {511'd0, BUSY_READY});
        n = 0;
        while (d_valid !== 1'b1 && n < 40) begin
            if (inject && n == LAT - 1) begin
                init_valid = 1'b1;
                init_index = IW'(idx);
                init_line  = new_line;
            end
            step();
            init_valid = 1'b0;
            n++;
        end
        if (inject) begin
            mem_model[idx] = new_line;
        end
        check("latency", BW'(n), BW'(LAT + 1));
        check("data", d_data, exp_line);
        for (int i = 0; i < bp; i++) begin
            step();
            check("bp_valid", {511'd0, d_valid}, {511'd0, 1'b1});
            check("bp_data", d_data, exp_line);
        end
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        check("hs_valid_low", {511'd0, d_valid}, {511'd0, 1'b0});
        check("hs_ready_back", {511'd0, a_ready}, {511'd0, 1'b1});
    endtask

    initial begin
        int n;
        logic [BW-1:0] first_line;
        rst        = 1'b1;
        a_valid    = 1'b0;
        a_addr     = '0;
        d_ready    = 1'b0;
        init_valid = 1'b0;
        init_index = '0;
        init_line  = '0;

        repeat (3) step();
        check("rst_ready", {511'd0, a_ready}, {511'd0, 1'b0});
        check("rst_valid", {511'd0, d_valid}, {511'd0, 1'b0});
        check("rst_data", d_data, {BW{1'b0}});

        // Preload every line while still in reset; memory writes ignore reset.
        for (int i = 0; i < LINES; i++) begin
            mem_model[i] = (i == 3) ? {64{8'hA5}} : rand_line();
            init_valid   = 1'b1;
            init_index   = IW'(i);
            init_line    = mem_model[i];
            step();
        end
        init_valid = 1'b0;

        rst = 1'b0;
        #1;
        check("ready_before_edge", {511'd0, a_ready}, {511'd0, 1'b0});
        step();
        check("ready_after_release", {511'd0, a_ready}, {511'd0, 1'b1});

        // Basic fill with long backpressure, then other offsets within the line.
        do_fill(30'h0000_0030, 10, 1'b0);
        do_fill(30'h0000_003F, 0, 1'b0);
        do_fill(30'h0000_0035, 2, 1'b0);

        // Aliasing with a same-edge preload write: old line returned, then new.
        do_fill(30'h0001_0030, 1, 1'b1);
        do_fill(30'h0000_0031, 0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            do_fill(30'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        // Reset while waiting on the latency counter.
        a_addr  = 30'h0000_0040;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("rstwait_valid", {511'd0, d_valid}, {511'd0, 1'b0});
        check("rstwait_ready", {511'd0, a_ready}, {511'd0, 1'b0});
        step();
        rst = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            check("rstwait_no_stale", {511'd0, d_valid}, {511'd0, 1'b0});
        end
        do_fill(30'h0000_0040, 1, 1'b0);

        // Reset while a response is being held.
        a_addr  = 30'h0000_0123;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        wait_valid(n);
        check("rstresp_pre_valid", {511'd0, d_valid}, {511'd0, 1'b1});
        step();
        rst = 1'b1;
        #1;
        check("rstresp_valid", {511'd0, d_valid}, {511'd0, 1'b0});
        check("rstresp_data", d_data, {BW{1'b0}});
        step();
        rst = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            check("rstresp_no_stale", {511'd0, d_valid}, {511'd0, 1'b0});
        end
        do_fill(30'($urandom), 0, 1'b0);

`ifdef L2_INS_ADDR_QUEUE_EN
        // Second request during WAIT is queued; a third one is refused.
        first_line = mem_model[line_of(30'h0000_0200)];
        a_addr  = 30'h0000_0200;
        a_valid = 1'b1;
        step();
        a_addr = 30'h0000_0310;
        check("q_ready_in_wait", {511'd0, a_ready}, {511'd0, 1'b1});
        step();
        a_addr = 30'h0000_0420;
        check("q_ready_full", {511'd0, a_ready}, {511'd0, 1'b0});
        step();
        a_valid = 1'b0;
        wait_valid(n);
        check("q_first_data", d_data, first_line);
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        check("q_ready_popped", {511'd0, a_ready}, {511'd0, 1'b1});
        wait_valid(n);
        check("q_second_latency", BW'(n), BW'(LAT + 1));
        check("q_second_data", d_data, mem_model[line_of(30'h0000_0310)]);
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            step();
            check("q_third_refused", {511'd0, d_valid}, {511'd0, 1'b0});
        end
`else
        first_line = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
